// File: rtl/gf2_poly_long_divider.sv
// Bit-serial GF(2)[x] long divider: 2N-bit dividend by N-bit divisor.
// Finds deg(divisor) MSB-first, then consumes one dividend bit per cycle.
module gf2_poly_long_divider #(
    parameter int N = 384
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(2 * N);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DIVIDE,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [2*N-1:0] dvd_q;
    logic [N-1:0]   dvs_q;
    logic [N-1:0]   rem_q;
    logic [2*N-1:0] quo_q;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  deg;
    logic [SW-1:0]  step;
    logic [N-1:0]   t;
    logic           qbit;
    logic [N-1:0]   r_next;

    assign busy = (state == SCAN) || (state == DIVIDE);
    assign done = (state == DONE);

    // State register; reset always returns to IDLE
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (start) state_next = SCAN;
            SCAN: begin
                if (dvs_q[idx])     state_next = DIVIDE;
                else if (idx == '0) state_next = DONE;
            end
            DIVIDE: if (step == '0) state_next = DONE;
            DONE:   state_next = IDLE;
        endcase
    end

    // One division step: shift in the next dividend bit, subtract on a hit
    always_comb begin
        t      = (rem_q << 1) | N'(dvd_q[2*N-1]);
        qbit   = t[deg];
        r_next = qbit ? (t ^ dvs_q) : t;
    end

    // Operand capture, degree search, shift-and-reduce datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            idx         <= '0;
            deg         <= '0;
            step        <= '0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd_q       <= dividend;
                        dvs_q       <= divisor;
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        idx         <= IW'(N - 1);
                    end
                end
                SCAN: begin
                    if (dvs_q[idx]) begin
                        deg   <= idx;
                        rem_q <= '0;
                        quo_q <= '0;
                        step  <= SW'(2 * N - 1);
                    end else if (idx == '0) begin
                        div_by_zero <= 1'b1;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DIVIDE: begin
                    rem_q <= r_next;
                    quo_q <= {quo_q[2*N-2:0], qbit};
                    dvd_q <= dvd_q << 1;
                    step  <= step - SW'(1);
                    if (step == '0) begin
                        quotient  <= {quo_q[2*N-2:0], qbit};
                        remainder <= r_next;
                    end
                end
                DONE: ;
            endcase
        end
    end

endmodule

// File: doc/gf2_poly_long_divider.md
# gf2_poly_long_divider

Sequential GF(2)[x] polynomial long divider, the inverse companion of the team's carry-less Toom-Cook multipliers. It accepts a 2N-bit dividend, such as a multiplier product, and an N-bit divisor. It returns quotient and remainder, so a product c = a·b divided by b recovers a with a zero remainder. It is bit-serial (one dividend bit per cycle) with a start/done handshake, and is used for result checking and for modular reduction.

## Interface
- N, default 384: divisor width in bits; dividend and quotient are 2N bits, remainder is N bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  2N  dividend polynomial, bit i is the coefficient of x^i; captured when start is accepted.
- divisor  input  N  divisor polynomial; captured when start is accepted.
- busy  output  1  high in SCAN and DIVIDE.
- done  output  1  one-cycle pulse when results are valid.
- div_by_zero  output  1  set when the captured divisor was all-zero.
- quotient  output  2N  dividend div divisor over GF(2).
- remainder  output  N  dividend mod divisor over GF(2); degree < deg(divisor).

## Operation
- FSM states: IDLE, SCAN, DIVIDE, DONE.
- Reset value of every output is 0. FSM goes to IDLE; all internal registers clear.
- **IDLE:** start=1 is accepted.
  - Latch dividend and divisor.
  - Clear quotient, remainder and div_by_zero.
  - Set idx = N-1 and go to SCAN.
- **SCAN (degree search):** one divisor bit is examined per cycle, MSB first.
  - If divisor[idx]=1: d = idx; R = 0; step counter = 2N-1; go to DIVIDE.
  - Else if idx=0 (divisor all-zero): go to DONE with div_by_zero=1, quotient=0, remainder=0.
  - Else: idx = idx-1.
- **DIVIDE:** one step per cycle, consuming dividend bits MSB first (bit 2N-1 down to bit 0).
  - T = (R<<1) | dividend[step], kept to N bits. T never overflows, since deg R < d ≤ N-1.
  - If T[d]=1: R = T ^ divisor and qbit = 1. Otherwise R = T and qbit = 0.
  - Q = (Q<<1) | qbit.
  - When step = 0: copy Q to quotient and R to remainder, then go to DONE.
- **DONE:** done=1 for exactly one cycle, then go to IDLE.
- Arithmetic is XOR only; there are no carries.
- quotient, remainder and div_by_zero hold their values until the next accepted start.
- start while busy, or in DONE, is ignored and not queued.
- Input changes after acceptance have no effect.

## Timing
- Accept edge k (start=1 in IDLE). busy is high from cycle k+1 through the final DIVIDE cycle, or the final SCAN cycle on divide-by-zero.
- SCAN takes N-d cycles. DIVIDE takes exactly 2N cycles.
- done is high in the cycle after edge k+(N-d)+2N, which also ends with the FSM back in IDLE.
- Divide-by-zero: SCAN takes N cycles, and done is high in the cycle after edge k+N.
- Outputs are registered and become valid in the same cycle done rises.
- Back-to-back operation: start may be asserted in the cycle after done (IDLE); minimum spacing is done + 1 cycle.
- rst at any cycle, including mid-SCAN or mid-DIVIDE:
  - On the next edge, the FSM is in IDLE and all outputs are 0.
  - No done pulse is produced for the aborted operation.
- start and rst asserted together: rst wins.

## Test plan
- N=384, dividend=0x9, divisor=0x3 → quotient=0x7, remainder=0, div_by_zero=0; done 383+768 edges after acceptance.
- dividend=0xB, divisor=0x3 → quotient=0x6, remainder=0x1.
- divisor=0, any dividend → div_by_zero=1, quotient=0, remainder=0, done 384 edges after acceptance; busy low after done.
- divisor=1, dividend=all-ones (768 bits) → quotient=all-ones, remainder=0, latency 384+768.
- divisor=x^383+1, dividend=x^766 → quotient=x^383+1, remainder=1, latency 1+768. Then round-trip random a, b (b≠0) from the multiplier model: c/b → quotient=a, remainder=0.
- Control checks:
  - start pulsed mid-DIVIDE → ignored; the original result is unchanged.
  - rst asserted mid-DIVIDE → busy=0 and all outputs 0 next cycle, no done pulse.
  - A fresh start afterwards completes correctly.
